freq_lock_detector: RTL and testbench
=====================================

# freq_lock_detector

Frequency-based lock detector for the DPLL. It runs in the PLL output clock domain and samples the reference clock as data. Over a window of reference periods it counts output-clock cycles, compares the count with the programmed multiplication ratio, and drives a hysteretic `locked` flag plus measurement results. It is the consumer of the PLL output: it checks what the PFD/LPF/divider loop produced, and replaces the single-cycle up/down lock flag.

## Interface
- `RATIO`, 10: expected output cycles per reference period (N of the feedback divider).
- `WINDOW_REFS`, 16: reference periods per measurement window.
- `TOLERANCE`, 2: maximum |count − EXPECTED| for a good window.
- `LOCK_COUNT`, 4: consecutive good windows needed to assert lock.
- `UNLOCK_COUNT`, 2: consecutive bad windows needed to drop lock.
- `CNT_W`, 16: counter width. Must satisfy 2^CNT_W > 2·RATIO·WINDOW_REFS.

- `clk` in 1: PLL output clock. All logic is in this domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `clk_ref` in 1: reference clock, asynchronous to `clk`, sampled as data.
- `enable` in 1: run measurement. Low forces IDLE.
- `locked` out 1: hysteretic lock indicator.
- `meas_valid` out 1: one-cycle pulse when a window closes.
- `meas_count` out CNT_W: `clk` cycles in the last window.
- `freq_err` out signed CNT_W+1: meas_count − EXPECTED.
- `ref_lost` out 1: no reference edge within the timeout.

## Operation
- EXPECTED = RATIO·WINDOW_REFS. TIMEOUT = 2·EXPECTED.
- Reference edge pulse `ref_edge`:
  - `clk_ref` passes through a 2-flop synchronizer and then a third flop.
  - `ref_edge` = sync2 & ~sync3.
  - `ref_edge` is 1 for exactly one cycle per reference rising edge.
- States: IDLE, ALIGN, MEASURE.
  - IDLE: counters are cleared and `locked` = 0. Go to ALIGN when `enable` = 1.
  - ALIGN: wait for `ref_edge`. On it, set cycle_cnt = 1, set ref_cnt = 0, and go to MEASURE.
  - MEASURE: cycle_cnt increments every cycle and saturates at all-ones. ref_cnt increments on each `ref_edge`.
- Window close: a `ref_edge` arrives while ref_cnt = WINDOW_REFS−1.
  - `meas_count` ← cycle_cnt and `freq_err` ← cycle_cnt − EXPECTED.
  - Pulse `meas_valid`.
  - Set cycle_cnt = 1 and ref_cnt = 0, then stay in MEASURE. Windows are back-to-back with no dead cycle.
- Window quality:
  - Good: |freq_err| ≤ TOLERANCE.
  - On good, good_cnt increments, saturating at LOCK_COUNT, and bad_cnt clears.
  - On bad, the reverse: bad_cnt increments, saturating at UNLOCK_COUNT, and good_cnt clears.
- Lock hysteresis:
  - `locked` sets when good_cnt reaches LOCK_COUNT.
  - `locked` clears when bad_cnt reaches UNLOCK_COUNT.
  - Otherwise `locked` holds.
- Reference loss: when cycle_cnt reaches TIMEOUT in MEASURE without a window close:
  - Set `ref_lost` = 1 and `locked` = 0, and clear good_cnt and bad_cnt.
  - Go to ALIGN. `meas_valid` does not pulse.
  - `ref_lost` clears at the next window close.
- `enable` falling: go to IDLE on the next edge. `locked`, `meas_valid` and `ref_lost` clear there. `meas_count` and `freq_err` hold their values.
- Simultaneous events:
  - `ref_edge` on the same cycle as the timeout: the window close wins.
  - `enable` = 0 overrides everything.

## Timing
- Reset values: `locked`, `meas_valid` and `ref_lost` = 0. `meas_count` and `freq_err` = 0. State = IDLE. Synchronizer flops = 0.
- `ref_edge` occurs 3 `clk` edges after the `clk_ref` rising edge, with ±1 cycle of synchronizer uncertainty.
- Update timing:
  - `meas_valid`, `meas_count`, `freq_err` and `locked` all update on the `clk` edge that ends the window-close cycle.
  - `locked` changes in the same cycle that `meas_valid` = 1.
- An ideal input gives `meas_count` = EXPECTED exactly, because the synchronizer delay is constant.
- Minimum time to lock is LOCK_COUNT windows after the first aligned edge. With the defaults this is 64 reference periods.
- Asserting `rst_n` mid-window clears everything immediately (asynchronous). Measurement restarts from IDLE.

## Structure
- `dpll_pkg` holds:
  - the `lock_state_t` enum (IDLE/ALIGN/MEASURE);
  - a constant function for EXPECTED;
  - a signed abs helper.
- Sub-module `ref_edge_sync` contains the 2-flop synchronizer, the edge-detect flop, and the `ref_edge` output. The rest is flat in `freq_lock_detector`.
- The top level instantiates it on `pll_clk`. It drives the existing `locked` output with the `clk_ref` port connected.

## Test plan
- Ideal lock: `clk` = 100 MHz, `clk_ref` = 10 MHz, defaults, `enable` = 1 → every `meas_count` = 160 and `freq_err` = 0. `locked` rises on the 4th `meas_valid`.
- Out of tolerance: output 10.2× the reference → `meas_count` ≈ 163 and `freq_err` ≈ +3 per window. `locked` stays 0.
- Unlock hysteresis: lock at 10×, then shift to 10.25× → `locked` holds through the first bad window and drops on the 2nd. Returning to 10× relocks after 4 good windows.
- Reference loss: stop `clk_ref` while locked → 320 cycles after the last boundary, `ref_lost` = 1 and `locked` = 0 with no `meas_valid`. Restarting the reference clears `ref_lost` at the next window close.
- Enable/reset mid-window:
  - Drop `enable` at cycle 80 of a window → IDLE, `locked` = 0, `meas_count` holds. Re-enable → realign.
  - Pulse `rst_n` low mid-window → all outputs 0 immediately.

Source files
------------

// File: rtl/dpll_pkg.sv
// Shared types and helpers for the DPLL lock-detection logic.
`timescale 1ns/1ps
package dpll_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ALIGN   = 2'd1,
      MEASURE = 2'd2
   } lock_state_t;

   // Output-clock cycles expected in one full measurement window.
   function automatic int expected_count(input int ratio, input int refs);
      return ratio * refs;
   endfunction

   // Magnitude of a signed value.
   function automatic logic signed [31:0] abs_s32(input logic signed [31:0] v);
      return (v < 0) ? -v : v;
   endfunction

endpackage

// File: rtl/ref_edge_sync.sv
// Brings the reference clock into the clk domain as data and produces a
// single-cycle pulse for every reference rising edge.
`timescale 1ns/1ps
module ref_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic clk_ref,
   output logic ref_edge
);

   logic r_sync1;
   logic r_sync2;
   logic r_sync3;

   // Two-flop synchronizer followed by one history flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= clk_ref;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign ref_edge = r_sync2 & ~r_sync3;

endmodule

// File: rtl/freq_lock_detector.sv
// Frequency lock detector: counts clk cycles over WINDOW_REFS reference
// periods, compares against RATIO*WINDOW_REFS and keeps a hysteretic lock.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | measurement off, counters cleared, not locked
//   ALIGN   | waiting for a reference edge to start the first window
//   MEASURE | counting cycles; windows close back-to-back on ref edges
`timescale 1ns/1ps
module freq_lock_detector
   import dpll_pkg::*;
#(
   parameter int RATIO        = 10,
   parameter int WINDOW_REFS  = 16,
   parameter int TOLERANCE    = 2,
   parameter int LOCK_COUNT   = 4,
   parameter int UNLOCK_COUNT = 2,
   parameter int CNT_W        = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clk_ref,
   input  logic                    enable,
   output logic                    locked,
   output logic                    meas_valid,
   output logic [CNT_W-1:0]        meas_count,
   output logic signed [CNT_W:0]   freq_err,
   output logic                    ref_lost
);

   localparam int EXPECTED = expected_count(RATIO, WINDOW_REFS);
   localparam int TIMEOUT  = 2 * EXPECTED;
   localparam int REF_W    = (WINDOW_REFS > 1) ? $clog2(WINDOW_REFS) : 1;
   localparam int GOOD_W   = $clog2(LOCK_COUNT + 1);
   localparam int BAD_W    = $clog2(UNLOCK_COUNT + 1);

   localparam logic [REF_W-1:0]        REF_LAST  = REF_W'(WINDOW_REFS - 1);
   localparam logic [CNT_W-1:0]        TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [GOOD_W-1:0]       GOOD_MAX  = GOOD_W'(LOCK_COUNT);
   localparam logic [BAD_W-1:0]        BAD_MAX   = BAD_W'(UNLOCK_COUNT);
   localparam logic signed [CNT_W:0]   EXP_S     = (CNT_W + 1)'(EXPECTED);

   lock_state_t             r_state;
   logic [CNT_W-1:0]        r_cycle_cnt;
   logic [REF_W-1:0]        r_ref_cnt;
   logic [GOOD_W-1:0]       r_good_cnt;
   logic [BAD_W-1:0]        r_bad_cnt;
   logic                    r_locked;
   logic                    r_meas_valid;
   logic [CNT_W-1:0]        r_meas_count;
   logic signed [CNT_W:0]   r_freq_err;
   logic                    r_ref_lost;

   logic                    w_ref_edge;
   logic signed [CNT_W:0]   w_err;
   logic signed [31:0]      w_abs;
   logic                    w_good;
   logic                    w_close;
   logic                    w_timeout;
   logic [GOOD_W-1:0]       w_good_nxt;
   logic [BAD_W-1:0]        w_bad_nxt;

   ref_edge_sync u_ref_edge_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .clk_ref  (clk_ref),
      .ref_edge (w_ref_edge)
   );

   assign w_err     = $signed({1'b0, r_cycle_cnt}) - EXP_S;
   assign w_abs     = abs_s32(32'(w_err));
   assign w_good    = (w_abs <= TOLERANCE);
   assign w_close   = (r_state == MEASURE) && w_ref_edge && (r_ref_cnt == REF_LAST);
   assign w_timeout = (r_cycle_cnt >= TIMEOUT_C);

   // Quality history after the window now closing; good and bad runs reset each other.
   always_comb begin
      w_good_nxt = '0;
      w_bad_nxt  = '0;
      if (w_good) begin
         w_good_nxt = (r_good_cnt == GOOD_MAX) ? GOOD_MAX : r_good_cnt + 1'b1;
      end else begin
         w_bad_nxt  = (r_bad_cnt == BAD_MAX) ? BAD_MAX : r_bad_cnt + 1'b1;
      end
   end

   // Measurement FSM with registered outputs; a window close beats a timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_cycle_cnt  <= '0;
         r_ref_cnt    <= '0;
         r_good_cnt   <= '0;
         r_bad_cnt    <= '0;
         r_locked     <= 1'b0;
         r_meas_valid <= 1'b0;
         r_meas_count <= '0;
         r_freq_err   <= '0;
         r_ref_lost   <= 1'b0;
      end else begin
         r_meas_valid <= 1'b0;
         if (!enable) begin
            r_state     <= IDLE;
            r_cycle_cnt <= '0;
            r_ref_cnt   <= '0;
            r_good_cnt  <= '0;
            r_bad_cnt   <= '0;
            r_locked    <= 1'b0;
            r_ref_lost  <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_cycle_cnt <= '0;
                  r_ref_cnt   <= '0;
                  r_good_cnt  <= '0;
                  r_bad_cnt   <= '0;
                  r_locked    <= 1'b0;
                  r_state     <= ALIGN;
               end
               ALIGN: begin
                  if (w_ref_edge) begin
                     r_cycle_cnt <= CNT_W'(1);
                     r_ref_cnt   <= '0;
                     r_state     <= MEASURE;
                  end
               end
               MEASURE: begin
                  if (w_close) begin
                     r_meas_count <= r_cycle_cnt;
                     r_freq_err   <= w_err;
                     r_meas_valid <= 1'b1;
                     r_ref_lost   <= 1'b0;
                     r_good_cnt   <= w_good_nxt;
                     r_bad_cnt    <= w_bad_nxt;
                     if (w_good_nxt == GOOD_MAX) begin
                        r_locked <= 1'b1;
                     end else if (w_bad_nxt == BAD_MAX) begin
                        r_locked <= 1'b0;
                     end
                     r_cycle_cnt  <= CNT_W'(1);
                     r_ref_cnt    <= '0;
                  end else if (w_timeout) begin
                     r_ref_lost  <= 1'b1;
                     r_locked    <= 1'b0;
                     r_good_cnt  <= '0;
                     r_bad_cnt   <= '0;
                     r_cycle_cnt <= '0;
                     r_ref_cnt   <= '0;
                     r_state     <= ALIGN;
                  end else begin
                     if (r_cycle_cnt != '1) begin
                        r_cycle_cnt <= r_cycle_cnt + 1'b1;
                     end
                     if (w_ref_edge) begin
                        r_ref_cnt <= r_ref_cnt + 1'b1;
                     end
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign locked     = r_locked;
   assign meas_valid = r_meas_valid;
   assign meas_count = r_meas_count;
   assign freq_err   = r_freq_err;
   assign ref_lost   = r_ref_lost;

endmodule

// File: tb/tb_freq_lock_detector.sv
// Scoreboard bench for freq_lock_detector: clk at 100 MHz, clk_ref generated
// with per-window periods so that every window count is an exact integer.
`timescale 1ns/1ps
module tb_freq_lock_detector;

   localparam int EXP_CNT = 160;
   localparam int TOL     = 2;
   localparam int LOCKN   = 4;
   localparam int UNLOCKN = 2;

   typedef struct {
      int cnt;
      int err;
      bit lkd;
   } exp_t;

   logic               clk     = 1'b0;
   logic               rst_n   = 1'b0;
   logic               clk_ref = 1'b0;
   logic               enable  = 1'b0;
   logic               locked;
   logic               meas_valid;
   logic [15:0]        meas_count;
   logic signed [16:0] freq_err;
   logic               ref_lost;

   exp_t sb_q[$];
   int   n_total = 0;
   int   n_bad   = 0;
   int   n_valid = 0;

   int   mdl_good   = 0;
   int   mdl_bad    = 0;
   bit   mdl_locked = 1'b0;
   int   mdl_cnt    = 0;
   int   mdl_err    = 0;

   freq_lock_detector dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clk_ref    (clk_ref),
      .enable     (enable),
      .locked     (locked),
      .meas_valid (meas_valid),
      .meas_count (meas_count),
      .freq_err   (freq_err),
      .ref_lost   (ref_lost)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mdl_good   = 0;
      mdl_bad    = 0;
      mdl_locked = 1'b0;
   endtask

   task automatic model_window(input int c);
      exp_t e;
      int   a;
      mdl_cnt = c;
      mdl_err = c - EXP_CNT;
      a = (mdl_err < 0) ? -mdl_err : mdl_err;
      if (a <= TOL) begin
         mdl_bad  = 0;
         mdl_good = (mdl_good < LOCKN) ? mdl_good + 1 : LOCKN;
      end else begin
         mdl_good = 0;
         mdl_bad  = (mdl_bad < UNLOCKN) ? mdl_bad + 1 : UNLOCKN;
      end
      if (mdl_good == LOCKN) mdl_locked = 1'b1;
      else if (mdl_bad == UNLOCKN) mdl_locked = 1'b0;
      e.cnt = mdl_cnt;
      e.err = mdl_err;
      e.lkd = mdl_locked;
      sb_q.push_back(e);
   endtask

   task automatic gen_periods(input int n, input real half);
      for (int i = 0; i < n; i++) begin
         clk_ref = 1'b1;
         #(half);
         clk_ref = 1'b0;
         #(half);
      end
   endtask

   // Each window is 16 whole reference periods; its first rising edge is
   // the alignment edge or the close of the previous window.
   task automatic gen_windows(input int n, input real half);
      for (int w = 0; w < n; w++) begin
         model_window($rtoi(32.0 * half / 10.0 + 0.5));
         gen_periods(16, half);
      end
   endtask

   // Scoreboard consumer
   always @(negedge clk) begin
      if (rst_n && meas_valid) begin
         exp_t e;
         n_valid++;
         if (sb_q.size() == 0) begin
            chk("unexpected_valid", sb_q.size(), 1);
         end else begin
            e = sb_q.pop_front();
            chk("meas_count", meas_count, e.cnt);
            chk("freq_err", freq_err, e.err);
            chk("locked_at_valid", locked, e.lkd);
            chk("ref_lost_at_valid", ref_lost, 0);
         end
      end
   end

   initial begin
      #300us;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      #2.3;
      #40;
      chk("rst_locked", locked, 0);
      chk("rst_meas_valid", meas_valid, 0);
      chk("rst_ref_lost", ref_lost, 0);
      chk("rst_meas_count", meas_count, 0);
      chk("rst_freq_err", freq_err, 0);
      rst_n = 1'b1;
      #20;
      enable = 1'b1;
      #25;

      // out of tolerance (163 per window), then ideal lock, unlock at +4, relock
      gen_windows(3, 50.9375);
      gen_windows(5, 50.0);
      gen_windows(2, 51.25);
      gen_windows(4, 50.0);

      // reference loss: close the last window then stop clk_ref
      clk_ref = 1'b1;
      #50;
      clk_ref = 1'b0;
      #50;
      n0 = n_valid;
      #2900;
      chk("pre_timeout_ref_lost", ref_lost, 0);
      chk("pre_timeout_locked", locked, mdl_locked);
      #400;
      chk("timeout_ref_lost", ref_lost, 1);
      chk("timeout_locked", locked, 0);
      chk("timeout_no_valid", n_valid - n0, 0);
      model_reset();

      // restart reference: realign, relock, then drop enable ~80 cycles in
      gen_windows(4, 50.0);
      gen_periods(8, 50.0);
      enable = 1'b0;
      @(posedge clk);
      #1;
      chk("dis_locked", locked, 0);
      chk("dis_meas_valid", meas_valid, 0);
      chk("dis_ref_lost", ref_lost, 0);
      chk("dis_meas_count_hold", meas_count, mdl_cnt);
      chk("dis_freq_err_hold", freq_err, mdl_err);
      model_reset();
      #30;
      enable = 1'b1;
      #25;
      gen_windows(1, 50.0);
      gen_periods(5, 50.0);

      // asynchronous reset mid-window
      rst_n = 1'b0;
      #1;
      chk("arst_locked", locked, 0);
      chk("arst_meas_valid", meas_valid, 0);
      chk("arst_ref_lost", ref_lost, 0);
      chk("arst_meas_count", meas_count, 0);
      chk("arst_freq_err", freq_err, 0);
      #3;
      rst_n = 1'b1;
      model_reset();
      #25;
      gen_windows(1, 50.0);
      clk_ref = 1'b1;
      #50;
      clk_ref = 1'b0;
      #200;
      chk("sb_drained", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
